// File: rtl/mcycle_cpu_if.sv
// Memory-side bundle of mcycle_cpu: instruction fetch port and data access port.
// Each request is held until its ack is sampled on a rising edge.
interface mcycle_cpu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mcycle_cpu.sv
// Multi-cycle CPU: 32 x DATA_W register file, 8 opcodes, FETCH/DECODE/EXEC/[MEM]/WB.
// 4 cycles per ALU/branch, 5 per load/store at zero wait; every ack wait cycle stretches by one.
module mcycle_cpu #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  mcycle_cpu_if.master      bus,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              retire
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_BEQ = 3'd2;
  localparam logic [2:0] OP_J   = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_OR  = 3'd7;

  logic [2:0]        state_nxt;
  logic [31:0]       ir;
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] ld_q;
  logic              br_q;

  logic [2:0]        ir_op;
  logic [4:0]        ir_rs0;
  logic [4:0]        ir_rs1;
  logic [4:0]        ir_rd;
  logic [ADDR_W-1:0] ir_tgt;
  logic              ir_unused;
  logic              is_mem_op;

  assign ir_op     = ir[31:29];
  assign ir_rs0    = ir[28:24];
  assign ir_rs1    = ir[23:19];
  assign ir_rd     = ir[18:14];
  assign ir_tgt    = ir[ADDR_W-1:0];
  assign ir_unused = ^ir;
  assign is_mem_op = (ir_op == OP_LW) || (ir_op == OP_SW);

  // Bus outputs come straight from state/ir/op_a, all frozen while a request is open.
  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && (ir_op == OP_SW);
  assign bus.dmem_addr  = ir_tgt;
  assign bus.dmem_wdata = op_a;
  assign retire         = (state == S_WB);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = is_mem_op ? S_MEM : S_WB;
      S_MEM:    if (bus.dmem_ack) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      alu_q <= '0;
      ld_q  <= '0;
      br_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir <= bus.imem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          op_a <= rf[ir_rs0];
          op_b <= rf[ir_rs1];
        end
        S_EXEC: begin
          case (ir_op)
            OP_ADD:  alu_q <= op_a + op_b;
            OP_SUB:  alu_q <= op_a - op_b;
            OP_AND:  alu_q <= op_a & op_b;
            OP_OR:   alu_q <= op_a | op_b;
            default: alu_q <= alu_q;
          endcase
          br_q <= (ir_op == OP_J) || ((ir_op == OP_BEQ) && (op_a == op_b));
        end
        S_MEM: begin
          if (bus.dmem_ack) ld_q <= bus.dmem_rdata;
        end
        S_WB: begin
          if (br_q) pc <= ir_tgt;
        end
        default: ;
      endcase
    end
  end

  // R0 is never written, so it reads as zero without a read-side mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB) begin
      if (ir_op == OP_LW && ir_rs0 != 5'd0)
        rf[ir_rs0] <= ld_q;
      else if (ir_op[2] && ir_rd != 5'd0)
        rf[ir_rd] <= alu_q;
    end
  end

endmodule
